// File: rtl/simpleuart_pkg.sv
// ---------------------------------------------------------------------------
// simpleuart_pkg: shared encodings for the configurable FIFO UART.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package simpleuart_pkg;

  localparam logic [1:0] c_PAR_NONE = 2'b00;
  localparam logic [1:0] c_PAR_EVEN = 2'b01;
  localparam logic [1:0] c_PAR_ODD  = 2'b10;

  localparam int c_CFG_PAR_LO = 2;
  localparam int c_CFG_STOP2  = 4;
  localparam int c_CFG_RXIE   = 5;
  localparam int c_CFG_TXIE   = 6;

  localparam int c_ST_OVR    = 0;
  localparam int c_ST_FERR   = 1;
  localparam int c_ST_PERR   = 2;
  localparam int c_ST_RXNE   = 3;
  localparam int c_ST_TXFULL = 4;
  localparam int c_ST_TXBUSY = 5;

  localparam logic [2:0] c_S_IDLE   = 3'd0;
  localparam logic [2:0] c_S_START  = 3'd1;
  localparam logic [2:0] c_S_DATA   = 3'd2;
  localparam logic [2:0] c_S_PARITY = 3'd3;
  localparam logic [2:0] c_S_STOP   = 3'd4;

  // Parity bit over data[last:0]; odd selects odd parity.
  function automatic logic par_calc(input logic [7:0] data, input logic [2:0] last,
                                    input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i[2:0] <= last) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo: first-word-fall-through synchronous FIFO.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr;
  logic [c_AW-1:0]  r_rd;
  logic [c_AW:0]    r_cnt;
  logic             w_pop;
  logic             w_push;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_pop  = i_pop && (r_cnt != '0);
  assign w_push = i_push && ((r_cnt != c_FULL) || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd];
  assign o_full  = (r_cnt == c_FULL);
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

endmodule

`default_nettype wire

// File: rtl/simpleuart_fifo.sv
// ---------------------------------------------------------------------------
// simpleuart_fifo: UART with runtime framing, TX/RX FIFOs, sticky errors, irq.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module simpleuart_fifo
  import simpleuart_pkg::*;
#(
  parameter logic [31:0] DEFAULT_DIV = 32'd104,
  parameter int          TX_DEPTH    = 16,
  parameter int          RX_DEPTH    = 16,
  parameter logic [31:0] DEFAULT_CFG = 32'h0000_0003
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ser_tx,
  input  logic        ser_rx,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_cfg_we,
  input  logic [31:0] reg_cfg_di,
  output logic [31:0] reg_cfg_do,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait,
  input  logic        reg_stat_we,
  input  logic [31:0] reg_stat_di,
  output logic [31:0] reg_stat_do,
  output logic        irq
);

  logic [31:0] r_div;
  logic [6:0]  r_cfg;
  logic [31:0] w_period;
  logic [2:0]  w_cfg_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div <= DEFAULT_DIV;
      r_cfg <= DEFAULT_CFG[6:0];
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (reg_div_we[b]) r_div[b*8 +: 8] <= reg_div_di[b*8 +: 8];
      end
      if (reg_cfg_we) r_cfg <= reg_cfg_di[6:0];
    end
  end

  assign w_period   = (r_div < 32'd4) ? 32'd4 : r_div;
  assign w_cfg_last = {1'b0, r_cfg[1:0]} + 3'd4;

  // ---------------- receiver ----------------
  logic        r_rx_s1, r_rx_s2;
  logic [2:0]  r_rx_state, r_rx_last, r_rx_bit;
  logic [31:0] r_rx_per, r_rx_cnt;
  logic [1:0]  r_rx_par;
  logic [7:0]  r_rx_data;
  logic        r_rx_perr, r_rx_hold;
  logic        w_rx_tick, w_rx_half, w_rx_par_en, w_rx_push, w_rx_pop;
  logic [9:0]  w_rx_wdata, w_rx_rdata;
  logic        w_rx_full, w_rx_empty;
  logic [$clog2(RX_DEPTH):0] w_rx_count;

  assign w_rx_tick   = (r_rx_cnt == r_rx_per - 32'd1);
  assign w_rx_half   = (r_rx_cnt == (r_rx_per >> 1) - 32'd1);
  assign w_rx_par_en = (r_rx_par == c_PAR_EVEN) || (r_rx_par == c_PAR_ODD);
  assign w_rx_push   = (r_rx_state == c_S_STOP) && w_rx_tick;
  assign w_rx_wdata  = {r_rx_perr, ~r_rx_s2, r_rx_data};
  assign w_rx_pop    = reg_dat_re && !w_rx_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_state <= c_S_IDLE;
      r_rx_per   <= 32'd4;
      r_rx_cnt   <= '0;
      r_rx_last  <= 3'd7;
      r_rx_par   <= c_PAR_NONE;
      r_rx_bit   <= '0;
      r_rx_data  <= '0;
      r_rx_perr  <= 1'b0;
      r_rx_hold  <= 1'b0;
    end else begin
      r_rx_s1 <= ser_rx;
      r_rx_s2 <= r_rx_s1;
      case (r_rx_state)
        c_S_IDLE: begin
          r_rx_cnt <= '0;
          // After a framing error the line must return high before re-arming.
          if (r_rx_hold) begin
            if (r_rx_s2) r_rx_hold <= 1'b0;
          end else if (!r_rx_s2) begin
            r_rx_state <= c_S_START;
            r_rx_per   <= w_period;
            r_rx_last  <= w_cfg_last;
            r_rx_par   <= r_cfg[c_CFG_PAR_LO +: 2];
            r_rx_bit   <= '0;
            r_rx_data  <= '0;
            r_rx_perr  <= 1'b0;
          end
        end
        c_S_START: begin
          if (w_rx_half) begin
            r_rx_cnt   <= '0;
            r_rx_state <= r_rx_s2 ? c_S_IDLE : c_S_DATA;
          end else r_rx_cnt <= r_rx_cnt + 32'd1;
        end
        c_S_DATA: begin
          if (w_rx_tick) begin
            r_rx_cnt            <= '0;
            r_rx_data[r_rx_bit] <= r_rx_s2;
            if (r_rx_bit == r_rx_last) r_rx_state <= w_rx_par_en ? c_S_PARITY : c_S_STOP;
            else r_rx_bit <= r_rx_bit + 3'd1;
          end else r_rx_cnt <= r_rx_cnt + 32'd1;
        end
        c_S_PARITY: begin
          if (w_rx_tick) begin
            r_rx_cnt   <= '0;
            r_rx_perr  <= r_rx_s2 != par_calc(r_rx_data, r_rx_last, r_rx_par == c_PAR_ODD);
            r_rx_state <= c_S_STOP;
          end else r_rx_cnt <= r_rx_cnt + 32'd1;
        end
        c_S_STOP: begin
          if (w_rx_tick) begin
            r_rx_cnt   <= '0;
            r_rx_hold  <= !r_rx_s2;
            r_rx_state <= c_S_IDLE;
          end else r_rx_cnt <= r_rx_cnt + 32'd1;
        end
        default: r_rx_state <= c_S_IDLE;
      endcase
    end
  end

  uart_fifo #(.WIDTH(10), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(reset), .i_push(w_rx_push), .i_wdata(w_rx_wdata), .i_pop(w_rx_pop),
    .o_rdata(w_rx_rdata), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count)
  );

  // ---------------- transmitter ----------------
  logic [2:0]  r_tx_state, r_tx_last, r_tx_bit;
  logic [31:0] r_tx_per, r_tx_cnt;
  logic        r_tx_par_en, r_tx_stop2, r_tx_pbit, r_tx_out;
  logic [7:0]  r_tx_shift;
  logic        w_tx_tick, w_tx_end, w_tx_pop, w_tx_push, w_tx_busy;
  logic [7:0]  w_tx_rdata;
  logic        w_tx_full, w_tx_empty;
  logic [$clog2(TX_DEPTH):0] w_tx_count;

  assign w_tx_tick = (r_tx_cnt == r_tx_per - 32'd1);
  assign w_tx_end  = (r_tx_state == c_S_STOP) && w_tx_tick && !(r_tx_stop2 && r_tx_bit == 3'd0);
  // Popping at the end of the last stop bit gives back-to-back frames.
  assign w_tx_pop  = !w_tx_empty && ((r_tx_state == c_S_IDLE) || w_tx_end);
  assign w_tx_push = reg_dat_we && !w_tx_full;
  assign w_tx_busy = !w_tx_empty || (r_tx_state != c_S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_state  <= c_S_IDLE;
      r_tx_out    <= 1'b1;
      r_tx_per    <= 32'd4;
      r_tx_cnt    <= '0;
      r_tx_last   <= 3'd7;
      r_tx_bit    <= '0;
      r_tx_par_en <= 1'b0;
      r_tx_stop2  <= 1'b0;
      r_tx_pbit   <= 1'b0;
      r_tx_shift  <= '0;
    end else if (w_tx_pop) begin
      r_tx_state  <= c_S_START;
      r_tx_out    <= 1'b0;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
      r_tx_per    <= w_period;
      r_tx_last   <= w_cfg_last;
      r_tx_par_en <= (r_cfg[c_CFG_PAR_LO +: 2] == c_PAR_EVEN) ||
                     (r_cfg[c_CFG_PAR_LO +: 2] == c_PAR_ODD);
      r_tx_stop2  <= r_cfg[c_CFG_STOP2];
      r_tx_shift  <= w_tx_rdata;
      r_tx_pbit   <= par_calc(w_tx_rdata, w_cfg_last, r_cfg[c_CFG_PAR_LO +: 2] == c_PAR_ODD);
    end else begin
      r_tx_cnt <= w_tx_tick ? 32'd0 : r_tx_cnt + 32'd1;
      case (r_tx_state)
        c_S_IDLE: begin
          r_tx_out <= 1'b1;
          r_tx_cnt <= '0;
        end
        c_S_START: if (w_tx_tick) begin
          r_tx_state <= c_S_DATA;
          r_tx_out   <= r_tx_shift[0];
        end
        c_S_DATA: if (w_tx_tick) begin
          if (r_tx_bit == r_tx_last) begin
            r_tx_state <= r_tx_par_en ? c_S_PARITY : c_S_STOP;
            r_tx_out   <= r_tx_par_en ? r_tx_pbit : 1'b1;
            r_tx_bit   <= '0;
          end else begin
            r_tx_bit   <= r_tx_bit + 3'd1;
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_out   <= r_tx_shift[1];
          end
        end
        c_S_PARITY: if (w_tx_tick) begin
          r_tx_state <= c_S_STOP;
          r_tx_out   <= 1'b1;
        end
        c_S_STOP: if (w_tx_tick) begin
          if (r_tx_stop2 && r_tx_bit == 3'd0) r_tx_bit <= 3'd1;
          else r_tx_state <= c_S_IDLE;
        end
        default: r_tx_state <= c_S_IDLE;
      endcase
    end
  end

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(reset), .i_push(w_tx_push), .i_wdata(reg_dat_di[7:0]), .i_pop(w_tx_pop),
    .o_rdata(w_tx_rdata), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_count)
  );

  // ---------------- status, flags, irq ----------------
  logic       r_ovr, r_ferr, r_perr, r_irq;
  logic [2:0] w_clr;
  logic [8:0] w_rx_cnt9, w_tx_cnt9;
  logic [7:0] w_rx_cnt8, w_tx_cnt8;
  logic       w_unused;

  assign w_clr = reg_stat_we ? reg_stat_di[2:0] : 3'b000;

  // Set wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
      r_perr <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_ovr  <= (r_ovr  && !w_clr[c_ST_OVR])  || (w_rx_push && w_rx_full && !w_rx_pop);
      r_ferr <= (r_ferr && !w_clr[c_ST_FERR]) || (w_rx_push && !r_rx_s2);
      r_perr <= (r_perr && !w_clr[c_ST_PERR]) || (w_rx_push && r_rx_perr);
      r_irq  <= (r_cfg[c_CFG_RXIE] && !w_rx_empty) || (r_cfg[c_CFG_TXIE] && !w_tx_busy);
    end
  end

  assign w_rx_cnt9 = 9'(w_rx_count);
  assign w_tx_cnt9 = 9'(w_tx_count);
  assign w_rx_cnt8 = w_rx_cnt9[8] ? 8'hFF : w_rx_cnt9[7:0];
  assign w_tx_cnt8 = w_tx_cnt9[8] ? 8'hFF : w_tx_cnt9[7:0];

  assign ser_tx       = r_tx_out;
  assign irq          = r_irq;
  assign reg_div_do   = r_div;
  assign reg_cfg_do   = {25'b0, r_cfg};
  assign reg_dat_do   = w_rx_empty ? 32'hFFFF_FFFF : {22'b0, w_rx_rdata};
  assign reg_dat_wait = reg_dat_we && w_tx_full;
  assign reg_stat_do  = {8'b0, w_tx_cnt8, w_rx_cnt8, 2'b0, w_tx_busy, w_tx_full,
                         !w_rx_empty, r_perr, r_ferr, r_ovr};

  assign w_unused = ^{reg_cfg_di[31:7], reg_dat_di[31:8], reg_stat_di[31:3]};

endmodule

`default_nettype wire

// File: tb/tb_simpleuart_fifo.sv
// ---------------------------------------------------------------------------
// tb_simpleuart_fifo: directed self-checking bench for simpleuart_fifo.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_simpleuart_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ser_tx, ser_rx;
  logic [3:0]  reg_div_we = '0;
  logic [31:0] reg_div_di = '0;
  logic [31:0] reg_div_do;
  logic        reg_cfg_we = 1'b0;
  logic [31:0] reg_cfg_di = '0;
  logic [31:0] reg_cfg_do;
  logic        reg_dat_we = 1'b0;
  logic        reg_dat_re = 1'b0;
  logic [31:0] reg_dat_di = '0;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;
  logic        reg_stat_we = 1'b0;
  logic [31:0] reg_stat_di = '0;
  logic [31:0] reg_stat_do;
  logic        irq;

  logic        r_loop = 1'b0;
  logic        r_rx_drv = 1'b1;
  int          n_cmp = 0;
  int          n_bad = 0;

  assign ser_rx = r_loop ? ser_tx : r_rx_drv;

  always #5 clk = ~clk;

  simpleuart_fifo dut (
    .clk(clk), .reset(reset), .ser_tx(ser_tx), .ser_rx(ser_rx),
    .reg_div_we(reg_div_we), .reg_div_di(reg_div_di), .reg_div_do(reg_div_do),
    .reg_cfg_we(reg_cfg_we), .reg_cfg_di(reg_cfg_di), .reg_cfg_do(reg_cfg_do),
    .reg_dat_we(reg_dat_we), .reg_dat_re(reg_dat_re), .reg_dat_di(reg_dat_di),
    .reg_dat_do(reg_dat_do), .reg_dat_wait(reg_dat_wait),
    .reg_stat_we(reg_stat_we), .reg_stat_di(reg_stat_di), .reg_stat_do(reg_stat_do),
    .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr_div(input logic [31:0] v);
    @(negedge clk); reg_div_we = 4'hF; reg_div_di = v;
    @(negedge clk); reg_div_we = 4'h0;
  endtask

  task automatic wr_cfg(input logic [31:0] v);
    @(negedge clk); reg_cfg_we = 1'b1; reg_cfg_di = v;
    @(negedge clk); reg_cfg_we = 1'b0;
  endtask

  task automatic wr_stat(input logic [31:0] v);
    @(negedge clk); reg_stat_we = 1'b1; reg_stat_di = v;
    @(negedge clk); reg_stat_we = 1'b0;
  endtask

  // Holds the strobe until the TX FIFO accepts; returns on the negedge after the accepting edge.
  task automatic push(input logic [7:0] v);
    int t;
    t = 0;
    @(negedge clk); reg_dat_we = 1'b1; reg_dat_di = {24'h0, v}; #1;
    while (reg_dat_wait && t < 5000) begin
      @(negedge clk); #1; t++;
    end
    check("push_accept", {31'b0, reg_dat_wait}, 32'd0);
    @(negedge clk); reg_dat_we = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk); reg_dat_re = 1'b1;
    @(negedge clk); reg_dat_re = 1'b0;
  endtask

  task automatic wait_tx_idle(input int limit);
    int t;
    t = 0;
    while (reg_stat_do[5] && t < limit) begin
      @(negedge clk); t++;
    end
    check("tx_idle_bound", {31'b0, reg_stat_do[5]}, 32'd0);
  endtask

  // bits[i] is the i-th line level after the start bit; flen is start-to-idle length.
  task automatic tx_frame(input string tag, input logic [11:0] bits, input int nbits, input int flen);
    int n;
    check({tag, "_pre"}, {31'b0, ser_tx}, 32'd1);
    @(negedge clk);
    check({tag, "_start_edge"}, {31'b0, ser_tx}, 32'd0);
    repeat (8) @(negedge clk);
    n = 8;
    check({tag, "_start_mid"}, {31'b0, ser_tx}, 32'd0);
    for (int i = 0; i < nbits; i++) begin
      repeat (16) @(negedge clk);
      n += 16;
      check($sformatf("%s_bit%0d", tag, i), {31'b0, ser_tx}, {31'b0, bits[i]});
    end
    while (reg_stat_do[5] && n < 1000) begin
      @(negedge clk); n++;
    end
    check({tag, "_frame_len"}, n, flen);
  endtask

  task automatic rx_bit(input logic v);
    r_rx_drv = v;
    repeat (16) @(negedge clk);
  endtask

  logic [7:0] lb [20];

  initial begin
    for (int i = 0; i < 20; i++) lb[i] = 8'(8'h11 * (i + 3));

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ser_tx", {31'b0, ser_tx}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_div", reg_div_do, 32'd104);
    check("rst_cfg", reg_cfg_do, 32'h0000_0003);
    check("rst_dat", reg_dat_do, 32'hFFFF_FFFF);
    check("rst_stat", reg_stat_do, 32'h0);
    reset = 1'b0;

    // 8N1, divider 16
    wr_div(32'd16);
    check("div_rb", reg_div_do, 32'd16);
    push(8'hA5);
    tx_frame("a5", 12'h1A5, 9, 160);
    check("a5_idle_line", {31'b0, ser_tx}, 32'd1);

    // 7 data bits, even parity, 2 stop bits
    wr_cfg(32'h0000_0016);
    check("cfg_rb", reg_cfg_do, 32'h0000_0016);
    push(8'h41);
    tx_frame("41e2", 12'h341, 10, 176);

    // Loopback overrun
    wr_cfg(32'h0000_0003);
    r_loop = 1'b1;
    for (int i = 0; i < 20; i++) push(lb[i]);
    wait_tx_idle(5000);
    repeat (40) @(negedge clk);
    check("lb_rx_count", {24'h0, reg_stat_do[15:8]}, 32'd16);
    check("lb_overrun", {31'b0, reg_stat_do[0]}, 32'd1);
    check("lb_ferr", {31'b0, reg_stat_do[1]}, 32'd0);
    check("lb_rxne", {31'b0, reg_stat_do[3]}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("lb_data%0d", i), reg_dat_do, {24'h0, lb[i]});
      pop();
    end
    check("lb_empty", reg_dat_do, 32'hFFFF_FFFF);
    pop();
    check("lb_pop_empty", {24'h0, reg_stat_do[15:8]}, 32'd0);
    wr_stat(32'h1);
    check("lb_ovr_clr", {31'b0, reg_stat_do[0]}, 32'd0);
    r_loop = 1'b0;

    // Framing error on 0x3C, line then held low
    r_rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(((8'h3C >> i) & 8'h01) != 8'h00);
    rx_bit(1'b0);
    repeat (80) @(negedge clk);
    check("fe_count_low", {24'h0, reg_stat_do[15:8]}, 32'd1);
    r_rx_drv = 1'b1;
    repeat (48) @(negedge clk);
    check("fe_count", {24'h0, reg_stat_do[15:8]}, 32'd1);
    check("fe_data", reg_dat_do, 32'h0000_013C);
    check("fe_flag", {31'b0, reg_stat_do[1]}, 32'd1);
    check("fe_perr", {31'b0, reg_stat_do[2]}, 32'd0);
    pop();
    wr_stat(32'h2);
    check("fe_clr", {31'b0, reg_stat_do[1]}, 32'd0);

    // False start: 0.3 period glitch
    r_rx_drv = 1'b0;
    repeat (5) @(negedge clk);
    r_rx_drv = 1'b1;
    repeat (48) @(negedge clk);
    check("glitch_count", {24'h0, reg_stat_do[15:8]}, 32'd0);
    check("glitch_dat", reg_dat_do, 32'hFFFF_FFFF);

    // TX full during active frame, then TX-empty irq
    push(8'h01);
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    check("full_count", {24'h0, reg_stat_do[23:16]}, 32'd16);
    check("full_flag", {31'b0, reg_stat_do[4]}, 32'd1);
    @(negedge clk); reg_dat_we = 1'b1; reg_dat_di = 32'h0000_00EE; #1;
    check("full_wait", {31'b0, reg_dat_wait}, 32'd1);
    @(negedge clk); reg_dat_we = 1'b0;
    check("full_ignored", {24'h0, reg_stat_do[23:16]}, 32'd16);
    wr_cfg(32'h0000_0043);
    check("irq_busy", {31'b0, irq}, 32'd0);
    wait_tx_idle(4000);
    check("irq_at_idle", {31'b0, irq}, 32'd0);
    check("idle_line", {31'b0, ser_tx}, 32'd1);
    @(negedge clk);
    check("irq_rise", {31'b0, irq}, 32'd1);

    // Reset mid-frame
    wr_cfg(32'h0000_0003);
    push(8'h00);
    repeat (40) @(negedge clk);
    check("mid_low", {31'b0, ser_tx}, 32'd0);
    reset = 1'b1; #1;
    check("mid_rst_tx", {31'b0, ser_tx}, 32'd1);
    check("mid_rst_div", reg_div_do, 32'd104);
    check("mid_rst_stat", reg_stat_do, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
